// File: rtl/hazard_sequencer.sv
// Hazard/stall/flush controller with a drained forwarding-mode switch and an SRAM wait watchdog.
// Define HAZARD_PERF_CNT_EN to implement the stall_cycles / flush_count performance counters.
module hazard_sequencer #(
    parameter int unsigned MWAIT_TIMEOUT = 64,
    parameter bit          FWD_RESET     = 1'b1,
    parameter int unsigned PERF_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_cfg,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic              id_two_src,
    input  logic [3:0]        ex_dest,
    input  logic              ex_wb_en,
    input  logic              ex_mem_r_en,
    input  logic [3:0]        mem_dest,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_id,
    output logic              bubble_ex,
    output logic              flush,
    output logic              freeze_all,
    output logic              forward_en,
    output logic              mem_timeout,
    output logic [1:0]        state,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MWAIT = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam int unsigned     WAIT_W    = (MWAIT_TIMEOUT > 2) ? $clog2(MWAIT_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MWAIT_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ARM  = WAIT_W'(MWAIT_TIMEOUT - 2);

    state_t            state_q;
    logic              ret_drain;
    logic [1:0]        drain_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ex_match;
    logic              mem_match;
    logic              hazard;

    assign state = state_q;

    // Source-operand matches against the EX and MEM destinations
    assign ex_match  = (id_src1 == ex_dest)  || (id_two_src && (id_src2 == ex_dest));
    assign mem_match = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

    // With forwarding only a load in EX cannot be bypassed
    assign hazard = forward_en ? (ex_mem_r_en && ex_wb_en && ex_match)
                               : ((ex_wb_en && ex_match) || (mem_wb_en && mem_match));

    // Prioritised strobes: SRAM wait, then branch flush, then drain/hazard stall
    always_comb begin
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        bubble_ex  = 1'b0;
        flush      = 1'b0;
        freeze_all = 1'b0;
        if (rst) begin
            if (!mem_ready) begin
                freeze_all = 1'b1;
            end else if (branch_taken) begin
                flush = 1'b1;
            end else if ((state_q == DRAIN) || hazard) begin
                freeze_if = 1'b1;
                freeze_id = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            ret_drain   <= 1'b0;
            drain_cnt   <= 2'd0;
            wait_cnt    <= '0;
            forward_en  <= FWD_RESET;
            mem_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!mem_ready) begin
                        state_q   <= MWAIT;
                        ret_drain <= 1'b0;
                    end else if (!branch_taken && (fwd_cfg != forward_en)) begin
                        state_q   <= DRAIN;
                        drain_cnt <= 2'd2;
                    end
                end
                MWAIT: begin
                    if (mem_ready) begin
                        state_q  <= ret_drain ? DRAIN : RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != WAIT_LAST) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        // The increment landing on the last count raises the sticky flag
                        if (wait_cnt >= WAIT_ARM) begin
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!mem_ready) begin
                        state_q   <= MWAIT;
                        ret_drain <= 1'b1;
                    end else if (drain_cnt <= 2'd1) begin
                        drain_cnt  <= 2'd0;
                        forward_en <= fwd_cfg;
                        state_q    <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze_if || freeze_all) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the controller rules.
`timescale 1ns/1ps
module tb_hazard_sequencer;

    localparam int unsigned TMO     = 64;
    localparam bit          FWD_RST = 1'b1;
    localparam int unsigned PW      = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fwd_cfg = 1'b1;
    logic [3:0]    id_src1 = 4'd0, id_src2 = 4'd0, ex_dest = 4'd0, mem_dest = 4'd0;
    logic          id_two_src = 1'b0, ex_wb_en = 1'b0, ex_mem_r_en = 1'b0, mem_wb_en = 1'b0;
    logic          branch_taken = 1'b0, mem_ready = 1'b1;
    logic          freeze_if, freeze_id, bubble_ex, flush, freeze_all, forward_en, mem_timeout;
    logic [1:0]    state;
    logic [PW-1:0] stall_cycles, flush_count;
    logic [4:0]    strobes;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: pipeline mode, drain progress and run length of SRAM waits
    bit m_fe;
    int m_drain;
    bit m_wait;
    int m_low;
    bit m_tmo;
    int m_stall;
    int m_flush;

    hazard_sequencer #(.MWAIT_TIMEOUT(TMO), .FWD_RESET(FWD_RST), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .fwd_cfg(fwd_cfg),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .bubble_ex(bubble_ex),
        .flush(flush), .freeze_all(freeze_all), .forward_en(forward_en),
        .mem_timeout(mem_timeout), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign strobes = {freeze_if, freeze_id, bubble_ex, flush, freeze_all};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic bit reads(input logic [3:0] tag);
        return (id_src1 == tag) || (id_two_src && (id_src2 == tag));
    endfunction

    // Expected {freeze_if, freeze_id, bubble_ex, flush, freeze_all} for the current inputs
    function automatic logic [4:0] exp_strobes();
        bit hz;
        if (!rst)         return 5'b00000;
        if (!mem_ready)   return 5'b00001;
        if (branch_taken) return 5'b00010;
        if (m_fe) hz = ex_mem_r_en && ex_wb_en && reads(ex_dest);
        else      hz = (ex_wb_en && reads(ex_dest)) || (mem_wb_en && reads(mem_dest));
        if (hz || (m_drain > 0 && !m_wait)) return 5'b11100;
        return 5'b00000;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_wait)      return 2'b01;
        if (m_drain > 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [PW-1:0] exp_cnt(input int n);
        return PERF ? PW'(n) : '0;
    endfunction

    task automatic model_reset();
        m_fe = FWD_RST; m_drain = 0; m_wait = 0; m_low = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    endtask

    // One rising edge; the model advances with the inputs present at that edge
    task automatic step();
        logic [4:0] s;
        @(posedge clk);
        s = exp_strobes();
        if (!rst) begin
            model_reset();
        end else begin
            if (s[4] || s[0]) m_stall++;
            if (s[1]) m_flush++;
            if (!mem_ready) begin
                m_wait = 1;
                m_low++;
                if (m_low >= TMO) m_tmo = 1;
            end else begin
                m_low = 0;
                if (m_wait) begin
                    m_wait = 0;
                end else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_fe = fwd_cfg;
                end else if (!branch_taken && (fwd_cfg != m_fe)) begin
                    m_drain = 2;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        mem_ready = 1'b1; branch_taken = 1'b0;
        ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_wb_en = 1'b0; id_two_src = 1'b0;
        id_src1 = 4'd0; id_src2 = 4'd0; ex_dest = 4'd0; mem_dest = 4'd0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0; mem_ready = 1'b0; fwd_cfg = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({strobes, state, forward_en, mem_timeout} !== {5'b00000, 2'b00, FWD_RST, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {strobes, state, forward_en, mem_timeout}, {5'b00000, 2'b00, FWD_RST, 1'b0});
        end
        n_tests++;
        if ({stall_cycles, flush_count} !== {PW'(0), PW'(0)}) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cycles, flush_count);
        end
        step();
        fwd_cfg = 1'b1; mem_ready = 1'b1; rst = 1'b1;
    endtask

    task automatic test_load_use();
        idle(); fwd_cfg = 1'b1;
        ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd3; id_src1 = 4'd3;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b11100) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected 11100", strobes);
        end
        step();
        // The load has moved to MEM where forwarding covers it
        ex_mem_r_en = 1'b0; ex_wb_en = 1'b0; ex_dest = 4'd0; mem_wb_en = 1'b1; mem_dest = 4'd3;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b00000) begin
            n_fail++; $display("FAIL load_use_one_cycle: got %b expected 00000", strobes);
        end
        step();
        mem_wb_en = 1'b0; ex_wb_en = 1'b1; ex_dest = 4'd3;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b00000) begin
            n_fail++; $display("FAIL alu_no_stall: got %b expected 00000", strobes);
        end
        step();
    endtask

    task automatic test_branch();
        int prev;
        prev = m_flush;
        idle(); fwd_cfg = 1'b1;
        ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd7; id_src2 = 4'd7; id_two_src = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b00010) begin
            n_fail++; $display("FAIL branch_over_hazard: got %b expected 00010", strobes);
        end
        step();
        // A branch blocks entry into the drain even with a pending mode change
        idle(); branch_taken = 1'b1; fwd_cfg = 1'b0;
        step();
        branch_taken = 1'b0; fwd_cfg = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({state, flush_count} !== {2'b00, exp_cnt(prev + 2)}) begin
            n_fail++;
            $display("FAIL branch_count: got state %b count %0d expected state 00 count %0d",
                     state, flush_count, exp_cnt(prev + 2));
        end
        step();
    endtask

    task automatic test_mode_switch();
        idle(); fwd_cfg = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({state, strobes} !== {2'b00, 5'b00000}) begin
            n_fail++; $display("FAIL switch_start: got %b expected 0000000", {state, strobes});
        end
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({state, strobes, forward_en} !== {2'b10, 5'b11100, 1'b1}) begin
                n_fail++;
                $display("FAIL drain_bubble%0d: got %b expected 10111001", i, {state, strobes, forward_en});
            end
            step();
        end
        @(negedge clk);
        n_tests++;
        if ({state, strobes, forward_en} !== {2'b00, 5'b00000, 1'b0}) begin
            n_fail++; $display("FAIL switch_done: got %b expected 00000000", {state, strobes, forward_en});
        end
        step();
    endtask

    task automatic test_raw();
        idle(); fwd_cfg = 1'b0;
        mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b1; id_src1 = 4'd9;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b11100) begin
            n_fail++; $display("FAIL raw_mem_src2: got %b expected 11100", strobes);
        end
        step();
        id_two_src = 1'b0;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b00000) begin
            n_fail++; $display("FAIL raw_single_src: got %b expected 00000", strobes);
        end
        step();
        mem_wb_en = 1'b0; ex_wb_en = 1'b1; ex_dest = 4'd9;
        @(negedge clk);
        n_tests++;
        if (strobes !== 5'b11100) begin
            n_fail++; $display("FAIL raw_ex_src1: got %b expected 11100", strobes);
        end
        step();
    endtask

    task automatic test_mem_wait();
        idle(); fwd_cfg = 1'b0;
        ex_wb_en = 1'b1; ex_dest = 4'd9; id_src1 = 4'd9;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({state, strobes} !== {(i == 0) ? 2'b00 : 2'b01, 5'b00001}) begin
                n_fail++;
                $display("FAIL mem_wait%0d: got %b expected state %b strobes 00001", i, {state, strobes},
                         (i == 0) ? 2'b00 : 2'b01);
            end
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({state, strobes, mem_timeout} !== {2'b01, 5'b11100, 1'b0}) begin
            n_fail++; $display("FAIL mem_wait_exit: got %b expected 01111000", {state, strobes, mem_timeout});
        end
        n_tests++;
        if (stall_cycles !== exp_cnt(m_stall)) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", stall_cycles, exp_cnt(m_stall));
        end
        step();
    endtask

    task automatic test_timeout();
        idle(); fwd_cfg = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        @(negedge clk);
        n_tests++;
        if (mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got %b expected 0 after %0d cycles", mem_timeout, TMO - 1);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (mem_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_set: got %b expected 1 after %0d cycles", mem_timeout, TMO);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        n_tests++;
        if ({state, mem_timeout} !== {2'b00, 1'b1}) begin
            n_fail++; $display("FAIL timeout_sticky: got %b expected 001", {state, mem_timeout});
        end
        step();
    endtask

    task automatic test_reset_in_drain();
        idle(); fwd_cfg = 1'b1;
        step();
        @(negedge clk);
        n_tests++;
        if (state !== 2'b10) begin
            n_fail++; $display("FAIL drain_entered: got %b expected 10", state);
        end
        mem_ready = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd0;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({state, strobes, forward_en, mem_timeout} !== {2'b00, 5'b00000, FWD_RST, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got %b expected %b",
                     {state, strobes, forward_en, mem_timeout}, {2'b00, 5'b00000, FWD_RST, 1'b0});
        end
        n_tests++;
        if ({stall_cycles, flush_count} !== {PW'(0), PW'(0)}) begin
            n_fail++; $display("FAIL reset_mid_drain_cnt: got %h/%h expected 0/0", stall_cycles, flush_count);
        end
        model_reset();
        step();
        idle(); fwd_cfg = FWD_RST; rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({state, forward_en} !== {2'b00, FWD_RST}) begin
            n_fail++; $display("FAIL after_reset: got %b expected %b", {state, forward_en}, {2'b00, FWD_RST});
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            mem_ready    = ($urandom_range(7) != 0);
            branch_taken = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) fwd_cfg = ~fwd_cfg;
            id_src1     = 4'($urandom_range(3));
            id_src2     = 4'($urandom_range(3));
            id_two_src  = 1'($urandom_range(1));
            ex_dest     = 4'($urandom_range(3));
            ex_wb_en    = 1'($urandom_range(1));
            ex_mem_r_en = 1'($urandom_range(1));
            mem_dest    = 4'($urandom_range(3));
            mem_wb_en   = 1'($urandom_range(1));
            @(negedge clk);
            n_tests++;
            if ({state, strobes} !== {exp_state(), exp_strobes()}) begin
                n_fail++;
                $display("FAIL rand_strobes c%0d: got %b expected %b", c, {state, strobes},
                         {exp_state(), exp_strobes()});
            end
            n_tests++;
            if ({forward_en, mem_timeout} !== {m_fe, m_tmo}) begin
                n_fail++;
                $display("FAIL rand_mode c%0d: got %b expected %b", c, {forward_en, mem_timeout}, {m_fe, m_tmo});
            end
            n_tests++;
            if ({stall_cycles, flush_count} !== {exp_cnt(m_stall), exp_cnt(m_flush)}) begin
                n_fail++;
                $display("FAIL rand_counters c%0d: got %0d/%0d expected %0d/%0d", c, stall_cycles,
                         flush_count, exp_cnt(m_stall), exp_cnt(m_flush));
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mode_switch();
        test_raw();
        test_mem_wait();
        test_timeout();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
